// File: rtl/urv_divide_pkg.sv
// Shared definitions for the RV32M divider: funct3 codes, FSM state encoding
// and the magnitude helper used when latching signed operands.
package urv_divide_pkg;

   localparam logic [2:0] FUNC_DIV  = 3'b100;
   localparam logic [2:0] FUNC_DIVU = 3'b101;
   localparam logic [2:0] FUNC_REM  = 3'b110;
   localparam logic [2:0] FUNC_REMU = 3'b111;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_FIX  = 2'b10,
      DIV_DONE = 2'b11
   } div_state_e;

   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/urv_div_step.sv
// One restoring radix-2 division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits and record the quotient bit.
module urv_div_step (
   input  logic [31:0] r_i,
   input  logic [31:0] q_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] r_next_o,
   output logic [31:0] q_next_o
);

   logic [32:0] shifted;
   logic [33:0] diff;
   logic        ge;
   logic        step_unused;

   // Partial remainder is 33 bits wide so divisors above 2^31 still compare correctly.
   always_comb begin
      shifted  = {r_i, q_i[31]};
      diff     = {1'b0, shifted} - {2'b00, divisor_i};
      ge       = ~diff[33];
      r_next_o = ge ? diff[31:0] : shifted[31:0];
      q_next_o = {q_i[30:0], ge};
   end

   // When the subtraction succeeds the difference is below the divisor, so bit 32 is zero.
   assign step_unused = diff[32];

endmodule

// File: rtl/urv_divide.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU in the X stage.
// Define URV_DIV_EARLY_OUT_EN to skip iteration for divide-by-zero and signed overflow.
module urv_divide
   import urv_divide_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        x_stall_i,
   input  logic        x_kill_i,
   output logic        x_stall_req_o,
   input  logic [31:0] d_rs1_i,
   input  logic [31:0] d_rs2_i,
   input  logic [2:0]  d_fun_i,
   input  logic        d_is_divide_i,
   output logic [31:0] x_rd_o
);

   // Handshake: x_stall_req_o high means the result is not ready and X must hold;
   // the instruction retires in the DONE cycle, where the request is low and x_rd_o valid.

   div_state_e  state_q, state_d;
   logic [4:0]  counter_q, counter_d;
   logic [31:0] r_q, r_d;
   logic [31:0] q_q, q_d;
   logic [31:0] divisor_q, divisor_d;
   logic [31:0] rs1_q, rs1_d;
   logic [31:0] rd_q, rd_d;
   logic        rem_q, rem_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic        div0_q, div0_d;

   logic        start;
   logic        is_signed;
   logic        early_out;
   logic        stall_req;
   logic [31:0] step_r, step_q;
   logic [31:0] fix_q, fix_r;
   logic        fun_unused;

   assign fun_unused = d_fun_i[2];
   assign is_signed  = ~d_fun_i[0];
   assign start      = d_is_divide_i & ~x_kill_i;

`ifdef URV_DIV_EARLY_OUT_EN
   assign early_out = (d_rs2_i == 32'd0) |
                      (is_signed & (d_rs1_i == INT_MIN) & (d_rs2_i == ALL_ONES));
`else
   assign early_out = 1'b0;
`endif

   urv_div_step u_step (
      .r_i       (r_q),
      .q_i       (q_q),
      .divisor_i (divisor_q),
      .r_next_o  (step_r),
      .q_next_o  (step_q)
   );

   assign fix_q = qneg_q ? (32'd0 - q_q) : q_q;
   assign fix_r = rneg_q ? (32'd0 - r_q) : r_q;

   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      r_d       = r_q;
      q_d       = q_q;
      divisor_d = divisor_q;
      rs1_d     = rs1_q;
      rd_d      = rd_q;
      rem_d     = rem_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      div0_d    = div0_q;
      stall_req = 1'b0;

      case (state_q)
         DIV_IDLE: begin
            stall_req = start;
            if (start) begin
               rem_d     = d_fun_i[1];
               rs1_d     = d_rs1_i;
               div0_d    = (d_rs2_i == 32'd0);
               qneg_d    = is_signed & (d_rs1_i[31] ^ d_rs2_i[31]);
               rneg_d    = is_signed & d_rs1_i[31];
               q_d       = is_signed ? abs32(d_rs1_i) : d_rs1_i;
               divisor_d = is_signed ? abs32(d_rs2_i) : d_rs2_i;
               r_d       = 32'd0;
               counter_d = 5'd31;
               // With q=|rs1| and r=0, signed overflow already holds its final answer.
               state_d   = early_out ? DIV_FIX : DIV_BUSY;
            end
         end

         DIV_BUSY: begin
            stall_req = 1'b1;
            if (x_kill_i) begin
               state_d = DIV_IDLE;
            end else begin
               r_d = step_r;
               q_d = step_q;
               if (counter_q == 5'd0) begin
                  state_d = DIV_FIX;
               end else begin
                  counter_d = counter_q - 5'd1;
               end
            end
         end

         DIV_FIX: begin
            stall_req = 1'b1;
            if (x_kill_i) begin
               state_d = DIV_IDLE;
            end else begin
               if (div0_q) begin
                  rd_d = rem_q ? rs1_q : ALL_ONES;
               end else begin
                  rd_d = rem_q ? fix_r : fix_q;
               end
               state_d = DIV_DONE;
            end
         end

         DIV_DONE: begin
            // Leaving DONE never starts: the retiring instruction is not re-sampled.
            if (!x_stall_i) begin
               state_d = DIV_IDLE;
            end
         end

         default: begin
            state_d = DIV_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= DIV_IDLE;
         counter_q <= 5'd0;
         r_q       <= 32'd0;
         q_q       <= 32'd0;
         divisor_q <= 32'd0;
         rs1_q     <= 32'd0;
         rd_q      <= 32'd0;
         rem_q     <= 1'b0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         div0_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         r_q       <= r_d;
         q_q       <= q_d;
         divisor_q <= divisor_d;
         rs1_q     <= rs1_d;
         rd_q      <= rd_d;
         rem_q     <= rem_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         div0_q    <= div0_d;
      end
   end

   assign x_stall_req_o = stall_req;
   assign x_rd_o        = rd_q;

endmodule

// File: tb/tb_urv_divide.sv
// Directed and randomized checks of urv_divide against an arithmetic reference model.
`timescale 1ns/1ps
module tb_urv_divide;

   localparam logic [2:0] F_DIV  = 3'b100;
   localparam logic [2:0] F_DIVU = 3'b101;
   localparam logic [2:0] F_REM  = 3'b110;
   localparam logic [2:0] F_REMU = 3'b111;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        x_stall_i = 1'b0;
   logic        x_kill_i = 1'b0;
   logic        x_stall_req_o;
   logic [31:0] d_rs1_i = 32'd0;
   logic [31:0] d_rs2_i = 32'd0;
   logic [2:0]  d_fun_i = 3'd0;
   logic        d_is_divide_i = 1'b0;
   logic [31:0] x_rd_o;

   int check_cnt = 0;
   int pass_cnt  = 0;
   int fail_cnt  = 0;

   urv_divide dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .x_stall_i     (x_stall_i),
      .x_kill_i      (x_kill_i),
      .x_stall_req_o (x_stall_req_o),
      .d_rs1_i       (d_rs1_i),
      .d_rs2_i       (d_rs2_i),
      .d_fun_i       (d_fun_i),
      .d_is_divide_i (d_is_divide_i),
      .x_rd_o        (x_rd_o)
   );

   always #5 clk_i = ~clk_i;

   // RISC-V M-extension semantics from plain arithmetic.
   function automatic logic [31:0] model_rd(input logic [2:0] fun, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (fun[0]) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end
      return fun[1] ? r : q;
   endfunction

   function automatic int model_stall(input logic [2:0] fun, input logic [31:0] a,
                                      input logic [31:0] b);
`ifdef URV_DIV_EARLY_OUT_EN
      if (b == 32'd0 || (!fun[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
`endif
      return 34;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one divide, count stall cycles, check the result and optionally hold DONE.
   task automatic do_op(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_rd, input string tag, input int hold);
      int n;
      @(negedge clk_i);
      d_is_divide_i = 1'b1;
      d_fun_i = fun;
      d_rs1_i = a;
      d_rs2_i = b;
      n = 0;
      #1;
      while (x_stall_req_o === 1'b1 && n < 100) begin
         n++;
         @(negedge clk_i);
         #1;
      end
      check({tag, " stall_len"}, 32'(n), 32'(model_stall(fun, a, b)));
      check({tag, " rd"}, x_rd_o, exp_rd);
      for (int i = 0; i < hold; i++) begin
         x_stall_i = 1'b1;
         @(negedge clk_i);
         #1;
         check({tag, " hold stall"}, {31'd0, x_stall_req_o}, 32'd0);
         check({tag, " hold rd"}, x_rd_o, exp_rd);
      end
      x_stall_i = 1'b0;
      d_is_divide_i = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, b, e;
      logic [2:0]  fun;
      logic [1:0]  sel;
      logic [31:0] edges[6];
      edges[0] = 32'h0000_0000;
      edges[1] = 32'h0000_0001;
      edges[2] = 32'hFFFF_FFFF;
      edges[3] = 32'h8000_0000;
      edges[4] = 32'h7FFF_FFFF;
      edges[5] = 32'hFFFF_FFFE;

      repeat (3) @(negedge clk_i);
      #1;
      check("reset stall", {31'd0, x_stall_req_o}, 32'd0);
      check("reset rd", x_rd_o, 32'd0);
      rst_n_i = 1'b1;

      do_op(F_DIVU, 32'd100, 32'd7, 32'd14, "divu 100/7", 0);
      do_op(F_REMU, 32'd100, 32'd7, 32'd2, "remu 100/7", 0);
      do_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div -7/2", 0);
      do_op(F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem -7/2", 0);
      do_op(F_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, "rem 7/-2", 0);
      do_op(F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu 5/0", 0);
      do_op(F_REMU, 32'd5, 32'd0, 32'd5, "remu 5/0", 0);
      do_op(F_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, "div -5/0", 0);
      do_op(F_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, "rem -5/0", 0);
      do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div ovf", 0);
      do_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem ovf", 0);
      do_op(F_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, "divu big divisor", 0);
      do_op(F_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, "remu big divisor", 0);
      do_op(F_DIVU, 32'd100, 32'd7, 32'd14, "divu hold", 5);

      // Kill at BUSY cycle 10: request must drop and the old result must remain.
      @(negedge clk_i);
      d_is_divide_i = 1'b1;
      d_fun_i = F_DIVU;
      d_rs1_i = 32'd1000;
      d_rs2_i = 32'd3;
      #1;
      check("kill start stall", {31'd0, x_stall_req_o}, 32'd1);
      repeat (10) @(negedge clk_i);
      x_kill_i = 1'b1;
      #1;
      check("kill busy stall", {31'd0, x_stall_req_o}, 32'd1);
      @(negedge clk_i);
      #1;
      check("kill after stall", {31'd0, x_stall_req_o}, 32'd0);
      check("kill after rd", x_rd_o, 32'd14);
      x_kill_i = 1'b0;
      d_is_divide_i = 1'b0;
      do_op(F_DIVU, 32'd9, 32'd3, 32'd3, "divu 9/3 after kill", 0);

      // Asynchronous reset in the middle of an operation.
      @(negedge clk_i);
      d_is_divide_i = 1'b1;
      d_fun_i = F_DIV;
      d_rs1_i = 32'd12345;
      d_rs2_i = 32'd17;
      repeat (5) @(negedge clk_i);
      #2;
      d_is_divide_i = 1'b0;
      rst_n_i = 1'b0;
      #1;
      check("async rst stall", {31'd0, x_stall_req_o}, 32'd0);
      check("async rst rd", x_rd_o, 32'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      do_op(F_DIV, 32'd12345, 32'd17, 32'd726, "div after reset", 0);

      for (int k = 0; k < 40; k++) begin
         sel = 2'($urandom_range(0, 3));
         fun = {1'b1, sel};
         case ($urandom_range(0, 3))
            0: begin a = $urandom; b = $urandom; end
            1: begin a = $urandom_range(0, 40); b = $urandom_range(0, 9); end
            2: begin a = $urandom; b = $urandom_range(0, 3); end
            default: begin
               a = edges[$urandom_range(0, 5)];
               b = edges[$urandom_range(0, 5)];
            end
         endcase
         e = model_rd(fun, a, b);
         do_op(fun, a, b, e, $sformatf("rand%0d f=%b a=%h b=%h", k, fun, a, b), 0);
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
